i2c_slave_responder: RTL and testbench

- Bus-side responder (target) for the I2C block: the other end of the existing master transaction engine.
- Consumes the synchronized SDA/SCL lines, detects START/STOP, and matches a 7-bit address against bus_address.
- Receives bytes into the RX FIFO, or transmits bytes from the TX FIFO, and reports status to the register block via the Slave-side signals.
- Stretches SCL while the TX FIFO is empty, when enabled.

---
 rtl/i2c_slave_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// I2C target for 7-bit addressing: detects START/STOP, matches bus_address[6:0],
// moves write data to the RX FIFO and read data from the TX FIFO, stretching SCL when allowed.
`timescale 1ns/1ps
module i2c_slave_responder #(
    parameter int unsigned STRETCH_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SDA_sync,
    input  logic       SCL_sync,
    input  logic       ms_select,
    input  logic       address_mode,
    input  logic [9:0] bus_address,
    input  logic       en_clock_strech,
    input  logic [7:0] tx_data,
    input  logic       TX_fifo_empty,
    input  logic       RX_fifo_full,
    output logic [7:0] rx_data_slave,
    output logic       RX_write_enable_slave,
    output logic       TX_read_enable_slave,
    output logic       SDA_out_slave,
    output logic       SCL_out_slave,
    output logic       busy_slave,
    output logic       ack_error_set_slave,
    output logic       set_transaction_complete_slave
);

    // ms_select = 1 selects target mode; address_mode = 0 selects 7-bit addressing.
    localparam logic SLAVE      = 1'b1;
    localparam logic ADDR_7_BIT = 1'b0;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACKCHK, WAIT_STOP
    } state_t;

    state_t      state, state_n;
    logic        scl_prev, sda_prev;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift_reg, shift_n;
    logic        rw_bit, rw_n;
    logic        phase, phase_n;
    logic [31:0] stretch_cnt, stretch_n;
    logic [7:0]  rx_data_n;
    logic        rx_we_n, tx_re_n, sda_n, scl_n, busy_n, ack_err_n, complete_n;

    logic active, rise, fall, start_det, stop_det;
    logic unused_addr_bits;

    assign unused_addr_bits = ^bus_address[9:7];
    assign active    = (ms_select == SLAVE) && (address_mode == ADDR_7_BIT);
    assign rise      = !scl_prev && SCL_sync;
    assign fall      = scl_prev && !SCL_sync;
    assign start_det = sda_prev && !SDA_sync && SCL_sync;
    assign stop_det  = !sda_prev && SDA_sync && SCL_sync;

    // FIFO strobes are single-cycle: RX_write_enable_slave qualifies rx_data_slave in the
    // same cycle, TX_read_enable_slave pops the head that was consumed in that cycle.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift_reg;
        rw_n       = rw_bit;
        phase_n    = phase;
        stretch_n  = stretch_cnt;
        rx_data_n  = rx_data_slave;
        rx_we_n    = 1'b0;
        tx_re_n    = 1'b0;
        sda_n      = SDA_out_slave;
        scl_n      = SCL_out_slave;
        busy_n     = busy_slave;
        ack_err_n  = 1'b0;
        complete_n = 1'b0;

        if (!active) begin
            state_n   = IDLE;
            bit_cnt_n = 4'd0;
            shift_n   = 8'd0;
            rw_n      = 1'b0;
            phase_n   = 1'b0;
            stretch_n = 32'd0;
            rx_data_n = 8'd0;
            sda_n     = 1'b1;
            scl_n     = 1'b1;
            busy_n    = 1'b0;
        end else if (stop_det) begin
            state_n    = IDLE;
            phase_n    = 1'b0;
            stretch_n  = 32'd0;
            sda_n      = 1'b1;
            scl_n      = 1'b1;
            complete_n = busy_slave;
            busy_n     = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            phase_n   = 1'b0;
            stretch_n = 32'd0;
            sda_n     = 1'b1;
            scl_n     = 1'b1;
        end else begin
            case (state)
                IDLE, WAIT_STOP: begin
                    sda_n = 1'b1;
                    scl_n = 1'b1;
                end
                ADDR: begin
                    if (rise) begin
                        shift_n   = {shift_reg[6:0], SDA_sync};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rw_n = SDA_sync;
                            if (shift_reg[6:0] == bus_address[6:0]) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                                phase_n = 1'b0;
                            end else begin
                                state_n = WAIT_STOP;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK, RX_ACK: begin
                    // First fall pulls SDA low for the ACK slot, the second releases it.
                    if (fall) begin
                        if (!phase) begin
                            sda_n   = 1'b0;
                            phase_n = 1'b1;
                        end else begin
                            sda_n     = 1'b1;
                            phase_n   = 1'b0;
                            bit_cnt_n = 4'd0;
                            if (state == RX_ACK || !rw_bit) state_n = RX_BYTE;
                            else                            state_n = TX_LOAD;
                        end
                    end
                end
                RX_BYTE: begin
                    if (rise) begin
                        shift_n   = {shift_reg[6:0], SDA_sync};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (RX_fifo_full) begin
                                ack_err_n = 1'b1;
                                state_n   = WAIT_STOP;
                            end else begin
                                rx_data_n = {shift_reg[6:0], SDA_sync};
                                rx_we_n   = 1'b1;
                                phase_n   = 1'b0;
                                state_n   = RX_ACK;
                            end
                        end
                    end
                end
                TX_LOAD: begin
                    if (!TX_fifo_empty) begin
                        shift_n   = tx_data;
                        tx_re_n   = 1'b1;
                        sda_n     = tx_data[7];
                        bit_cnt_n = 4'd0;
                        stretch_n = 32'd0;
                        state_n   = TX_BYTE;
                    end else if (en_clock_strech &&
                                 (STRETCH_LIMIT == 32'd0 || stretch_cnt < STRETCH_LIMIT)) begin
                        scl_n     = 1'b0;
                        stretch_n = stretch_cnt + 32'd1;
                    end else begin
                        shift_n   = 8'hFF;
                        sda_n     = 1'b1;
                        bit_cnt_n = 4'd0;
                        stretch_n = 32'd0;
                        state_n   = TX_BYTE;
                    end
                end
                TX_BYTE: begin
                    // SCL held by a stretch is let go one cycle after the data is loaded.
                    if (!SCL_out_slave) scl_n = 1'b1;
                    if (fall) begin
                        if (bit_cnt == 4'd7) begin
                            sda_n   = 1'b1;
                            phase_n = 1'b0;
                            state_n = TX_ACKCHK;
                        end else begin
                            sda_n     = shift_reg[6];
                            shift_n   = {shift_reg[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                TX_ACKCHK: begin
                    if (rise) begin
                        if (!SDA_sync) phase_n = 1'b1;
                        else           state_n = WAIT_STOP;
                    end else if (fall && phase) begin
                        phase_n = 1'b0;
                        state_n = TX_LOAD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                          <= IDLE;
            scl_prev                       <= 1'b1;
            sda_prev                       <= 1'b1;
            bit_cnt                        <= 4'd0;
            shift_reg                      <= 8'd0;
            rw_bit                         <= 1'b0;
            phase                          <= 1'b0;
            stretch_cnt                    <= 32'd0;
            rx_data_slave                  <= 8'd0;
            RX_write_enable_slave          <= 1'b0;
            TX_read_enable_slave           <= 1'b0;
            SDA_out_slave                  <= 1'b1;
            SCL_out_slave                  <= 1'b1;
            busy_slave                     <= 1'b0;
            ack_error_set_slave            <= 1'b0;
            set_transaction_complete_slave <= 1'b0;
        end else begin
            state                          <= state_n;
            scl_prev                       <= SCL_sync;
            sda_prev                       <= SDA_sync;
            bit_cnt                        <= bit_cnt_n;
            shift_reg                      <= shift_n;
            rw_bit                         <= rw_n;
            phase                          <= phase_n;
            stretch_cnt                    <= stretch_n;
            rx_data_slave                  <= rx_data_n;
            RX_write_enable_slave          <= rx_we_n;
            TX_read_enable_slave           <= tx_re_n;
            SDA_out_slave                  <= sda_n;
            SCL_out_slave                  <= scl_n;
            busy_slave                     <= busy_n;
            ack_error_set_slave            <= ack_err_n;
            set_transaction_complete_slave <= complete_n;
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bit-banged I2C master driving the responder over a wired-AND bus, with a TX FIFO model,
// an RX scoreboard and a transaction-level model of what the target should answer.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

    localparam logic       SLAVE      = 1'b1;
    localparam logic       ADDR_7_BIT = 1'b0;
    localparam logic [6:0] OWN        = 7'h3A;
    localparam int         Q          = 3;
    localparam int         NEVER      = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       SDA_sync, SCL_sync;
    logic       ms_select, address_mode, en_clock_strech;
    logic [9:0] bus_address;
    logic [7:0] tx_data;
    logic       TX_fifo_empty, RX_fifo_full;
    logic [7:0] rx_data_slave;
    logic       RX_write_enable_slave, TX_read_enable_slave;
    logic       SDA_out_slave, SCL_out_slave, busy_slave;
    logic       ack_error_set_slave, set_transaction_complete_slave;

    always #5 clk = ~clk;

    assign SCL_sync = scl_m & SCL_out_slave;
    assign SDA_sync = sda_m & SDA_out_slave;

    i2c_slave_responder dut (
        .clk(clk), .rst(rst), .SDA_sync(SDA_sync), .SCL_sync(SCL_sync),
        .ms_select(ms_select), .address_mode(address_mode), .bus_address(bus_address),
        .en_clock_strech(en_clock_strech), .tx_data(tx_data), .TX_fifo_empty(TX_fifo_empty),
        .RX_fifo_full(RX_fifo_full), .rx_data_slave(rx_data_slave),
        .RX_write_enable_slave(RX_write_enable_slave), .TX_read_enable_slave(TX_read_enable_slave),
        .SDA_out_slave(SDA_out_slave), .SCL_out_slave(SCL_out_slave), .busy_slave(busy_slave),
        .ack_error_set_slave(ack_error_set_slave),
        .set_transaction_complete_slave(set_transaction_complete_slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_fifo[$];
    logic [7:0] wr_bytes[$];
    logic [7:0] tx_vals[$];
    logic [31:0] mon_exp;
    int c_rx = 0, c_pop = 0, c_err = 0, c_cmp = 0, c_sda_low = 0, c_stretch = 0, c_busy = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor and TX FIFO model, evaluated away from the DUT's active edge.
    always @(negedge clk) begin
        if (RX_write_enable_slave) begin
            c_rx++;
            mon_exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEAD;
            check("rx_data", {24'd0, rx_data_slave}, mon_exp);
        end
        if (TX_read_enable_slave) begin
            c_pop++;
            if (tx_fifo.size() != 0) tx_fifo.delete(0);
        end
        if (ack_error_set_slave)            c_err++;
        if (set_transaction_complete_slave) c_cmp++;
        if (!SDA_out_slave)                 c_sda_low++;
        if (!SCL_out_slave)                 c_stretch++;
        if (busy_slave)                     c_busy++;
        TX_fifo_empty = (tx_fifo.size() == 0);
        tx_data       = TX_fifo_empty ? 8'hC3 : tx_fifo[0];
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic scl_rise();
        int t;
        scl_m = 1'b1;
        @(negedge clk);
        t = 0;
        while (SCL_sync !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (SCL_sync !== 1'b1) check("scl_release", {31'd0, SCL_sync}, 32'd1);
    endtask

    task automatic send_bit(input logic b, output logic s);
        sda_m = b;
        wait_q();
        scl_rise();
        wait_q();
        s = SDA_sync;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        wait_q();
        scl_rise();
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_q();
        scl_rise();
        wait_q();
        sda_m = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(nack, s);
    endtask

    // Model: a write is ACKed byte-by-byte until the first byte offered while the RX FIFO is full.
    task automatic run_write(input logic [6:0] addr, input int full_at);
        logic ack, match, take;
        int rx0, err0, cmp0, sda0, busy0, n_ok;
        match = (addr == OWN) && (ms_select == SLAVE) && (address_mode == ADDR_7_BIT);
        rx0 = c_rx; err0 = c_err; cmp0 = c_cmp; sda0 = c_sda_low; busy0 = c_busy;
        n_ok = 0;
        bus_start();
        write_byte({addr, 1'b0}, ack);
        check("addr_ack", {31'd0, ack}, {31'd0, !match});
        check("busy_addr", {31'd0, busy_slave}, {31'd0, match});
        for (int i = 0; i < wr_bytes.size(); i++) begin
            take = match && (i < full_at);
            RX_fifo_full = (i >= full_at);
            if (take) exp_q.push_back(wr_bytes[i]);
            write_byte(wr_bytes[i], ack);
            check("data_ack", {31'd0, ack}, {31'd0, !take});
            if (take) n_ok++;
        end
        RX_fifo_full = 1'b0;
        bus_stop();
        repeat (4) @(negedge clk);
        check("rx_count", c_rx - rx0, n_ok);
        check("ack_err", c_err - err0, (match && full_at < wr_bytes.size()) ? 1 : 0);
        check("complete", c_cmp - cmp0, match ? 1 : 0);
        check("busy_end", {31'd0, busy_slave}, 32'd0);
        check("rx_left", exp_q.size(), 0);
        if (!match) begin
            check("sda_quiet", c_sda_low - sda0, 0);
            check("busy_quiet", c_busy - busy0, 0);
        end
    endtask

    // Model: a read returns the queued TX bytes in order, 0xFF once the FIFO runs dry.
    task automatic run_read(input logic [6:0] addr, input int n);
        logic ack, match;
        logic [7:0] b;
        int pop0, cmp0, str0, cnt;
        match = (addr == OWN) && (ms_select == SLAVE) && (address_mode == ADDR_7_BIT);
        cnt = tx_vals.size();
        foreach (tx_vals[i]) tx_fifo.push_back(tx_vals[i]);
        repeat (2) @(negedge clk);
        pop0 = c_pop; cmp0 = c_cmp; str0 = c_stretch;
        bus_start();
        write_byte({addr, 1'b1}, ack);
        check("addr_ack", {31'd0, ack}, {31'd0, !match});
        if (match) begin
            for (int i = 0; i < n; i++) begin
                read_byte(i == n - 1, b);
                check("rd_data", {24'd0, b}, (i < cnt) ? {24'd0, tx_vals[i]} : 32'hFF);
            end
        end
        check("busy_before_stop", {31'd0, busy_slave}, {31'd0, match});
        bus_stop();
        repeat (4) @(negedge clk);
        check("pops", c_pop - pop0, match ? ((n < cnt) ? n : cnt) : 0);
        check("complete", c_cmp - cmp0, match ? 1 : 0);
        check("no_stretch", c_stretch - str0, 0);
        tx_fifo.delete();
        en_clock_strech = 1'b0;
    endtask

    initial begin
        logic ack, s;
        logic [7:0] b;
        logic [6:0] addr;
        int n, cnt, full_at, str0, pop0, cmp0;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        ms_select = SLAVE; address_mode = ADDR_7_BIT; bus_address = {3'b101, OWN};
        en_clock_strech = 1'b0; RX_fifo_full = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_rx_data", {24'd0, rx_data_slave}, 32'd0);
        check("rst_lines", {30'd0, SDA_out_slave, SCL_out_slave}, 32'd3);
        check("rst_strobes", {27'd0, RX_write_enable_slave, TX_read_enable_slave, busy_slave,
                              ack_error_set_slave, set_transaction_complete_slave}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        wr_bytes = '{8'hA5};
        run_write(OWN, NEVER);
        wr_bytes = '{8'hFF};
        run_write(7'h11, NEVER);
        tx_vals = '{8'h5C, 8'h81};
        run_read(OWN, 2);
        wr_bytes = '{8'h33};
        run_write(OWN, 0);

        // Read from an empty TX FIFO with stretching: data appears after ~100 cycles.
        en_clock_strech = 1'b1;
        repeat (2) @(negedge clk);
        str0 = c_stretch; pop0 = c_pop; cmp0 = c_cmp;
        bus_start();
        write_byte({OWN, 1'b1}, ack);
        check("stretch_addr_ack", {31'd0, ack}, 32'd0);
        fork
            read_byte(1'b1, b);
            begin
                repeat (100) @(negedge clk);
                check("stretching", {31'd0, SCL_out_slave}, 32'd0);
                tx_fifo.push_back(8'h9E);
            end
        join
        check("stretch_data", {24'd0, b}, 32'h9E);
        check("stretch_len", {31'd0, (c_stretch - str0) >= 90}, 32'd1);
        bus_stop();
        repeat (4) @(negedge clk);
        check("stretch_pops", c_pop - pop0, 1);
        check("stretch_complete", c_cmp - cmp0, 1);
        tx_fifo.delete();
        en_clock_strech = 1'b0;

        tx_vals.delete();
        run_read(OWN, 1);

        ms_select = ~SLAVE;
        wr_bytes = '{8'h55};
        run_write(OWN, NEVER);
        ms_select = SLAVE;
        address_mode = ~ADDR_7_BIT;
        run_write(OWN, NEVER);
        address_mode = ADDR_7_BIT;
        repeat (4) @(negedge clk);

        // Asynchronous reset in the 4th bit of a data byte.
        bus_start();
        write_byte({OWN, 1'b0}, ack);
        send_bit(1'b0, s);
        send_bit(1'b1, s);
        send_bit(1'b0, s);
        sda_m = 1'b1;
        wait_q();
        scl_rise();
        check("busy_mid", {31'd0, busy_slave}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_rx_data", {24'd0, rx_data_slave}, 32'd0);
        check("arst_lines", {30'd0, SDA_out_slave, SCL_out_slave}, 32'd3);
        check("arst_strobes", {27'd0, RX_write_enable_slave, TX_read_enable_slave, busy_slave,
                               ack_error_set_slave, set_transaction_complete_slave}, 32'd0);
        repeat (3) @(negedge clk);
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        wr_bytes = '{8'h10};
        run_write(OWN, NEVER);

        for (int t = 0; t < 24; t++) begin
            addr = ($urandom_range(0, 2) != 0) ? OWN : 7'($urandom_range(0, 127));
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                wr_bytes.delete();
                for (int i = 0; i < n; i++) wr_bytes.push_back(8'($urandom_range(0, 255)));
                full_at = $urandom_range(0, 4);
                run_write(addr, full_at);
            end else begin
                cnt = $urandom_range(n - 1, n + 1);
                tx_vals.delete();
                for (int i = 0; i < cnt; i++) tx_vals.push_back(8'($urandom_range(0, 255)));
                en_clock_strech = (cnt >= n) ? 1'($urandom_range(0, 1)) : 1'b0;
                run_read(addr, n);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
